// File: rtl/gb_phase_ctrl.sv
// Frame sequencer for the gray-balance datapath: INIT RAM sweep after reset,
// then per frame a STAT phase (pixel collection) and a COMP phase (map rebuild).
module gb_phase_ctrl #(
  parameter int DIN_WIDTH    = 14,
  parameter int DOUT_WIDTH   = 10,
  parameter int EOP_DRAIN    = 2,
  parameter int COMP_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  err_clr,
  input  logic                  pix_valid,
  input  logic                  pix_ready,
  input  logic                  pix_sop,
  input  logic                  pix_eop,
  output logic                  pix_ready_gate,
  output logic                  state_comp,
  output logic                  comp_start,
  input  logic                  comp_done,
  output logic                  init_wr,
  output logic [DIN_WIDTH-1:0]  init_addr,
  output logic [DOUT_WIDTH-1:0] init_map_data,
  output logic [15:0]           frame_cnt,
  output logic                  timeout_err
);
  localparam int DRAIN_W = (EOP_DRAIN > 1) ? $clog2(EOP_DRAIN) : 1;
  localparam int TMO_W   = $clog2(COMP_TIMEOUT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(EOP_DRAIN - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(COMP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_STAT  = 3'd2,
    S_DRAIN = 3'd3,
    S_COMP  = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               init_arm;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [TMO_W-1:0]   comp_cnt;
  logic               beat;
  logic               init_last;
  logic               drain_last;
  logic               comp_expire;

  assign beat        = pix_valid & pix_ready;
  assign init_last   = (init_addr == {DIN_WIDTH{1'b1}});
  assign drain_last  = (drain_cnt == DRAIN_LAST);
  // A done on the final allowed cycle still counts as a completed frame.
  assign comp_expire = (comp_cnt == TMO_LAST) & ~comp_done;

  generate
    if (DOUT_WIDTH <= DIN_WIDTH) begin : g_map_trunc
      assign init_map_data = init_addr[DIN_WIDTH-1 -: DOUT_WIDTH];
    end else begin : g_map_pad
      assign init_map_data = {init_addr, {(DOUT_WIDTH - DIN_WIDTH){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_wr && init_last) state_nxt = S_IDLE;
      S_IDLE:  if (beat && pix_sop) state_nxt = pix_eop ? S_DRAIN : S_STAT;
      S_STAT:  if (beat && pix_eop) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_last) state_nxt = S_COMP;
      S_COMP:  if (comp_done || comp_expire) state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  // init_arm keeps init_wr low while reset is held and for the release cycle.
  always_comb begin
    pix_ready_gate = 1'b0;
    state_comp     = 1'b0;
    comp_start     = 1'b0;
    init_wr        = 1'b0;
    case (state)
      S_INIT:  init_wr = init_arm;
      S_IDLE:  pix_ready_gate = go;
      S_STAT:  pix_ready_gate = 1'b1;
      S_DRAIN: begin
        comp_start = drain_last;
        state_comp = drain_last;
      end
      S_COMP:  state_comp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_arm    <= 1'b0;
      init_addr   <= '0;
      drain_cnt   <= '0;
      comp_cnt    <= '0;
      frame_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      init_arm <= 1'b1;
      if (init_wr) init_addr <= init_addr + 1'b1;
      drain_cnt <= (state == S_DRAIN && !drain_last) ? drain_cnt + 1'b1 : '0;
      comp_cnt  <= (state == S_COMP) ? comp_cnt + 1'b1 : '0;
      if (state == S_COMP && comp_done) frame_cnt <= frame_cnt + 16'd1;
      // A timeout in the same cycle as err_clr leaves the flag set.
      if (state == S_COMP && comp_expire) timeout_err <= 1'b1;
      else if (err_clr)                   timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gb_phase_ctrl.sv
// Randomized bench for gb_phase_ctrl against a frame-level timing model.
module tb_gb_phase_ctrl;
  localparam int DIN_W  = 4;
  localparam int DOUT_W = 2;
  localparam int DRAIN  = 2;
  localparam int TMO    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic              err_clr;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sop;
  logic              pix_eop;
  logic              comp_done;
  logic              rdy_ds;
  logic              pix_ready_gate;
  logic              state_comp;
  logic              comp_start;
  logic              init_wr;
  logic              timeout_err;
  logic [DIN_W-1:0]  init_addr;
  logic [DOUT_W-1:0] init_map_data;
  logic [15:0]       frame_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_frames = 16'd0;
  logic        exp_err = 1'b0;

  assign pix_ready = pix_ready_gate & rdy_ds;
  always #5 clk = ~clk;

  gb_phase_ctrl #(
    .DIN_WIDTH   (DIN_W),
    .DOUT_WIDTH  (DOUT_W),
    .EOP_DRAIN   (DRAIN),
    .COMP_TIMEOUT(TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .err_clr       (err_clr),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_sop       (pix_sop),
    .pix_eop       (pix_eop),
    .pix_ready_gate(pix_ready_gate),
    .state_comp    (state_comp),
    .comp_start    (comp_start),
    .comp_done     (comp_done),
    .init_wr       (init_wr),
    .init_addr     (init_addr),
    .init_map_data (init_map_data),
    .frame_cnt     (frame_cnt),
    .timeout_err   (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_gate", 32'(pix_ready_gate), 0);
    chk("rst_comp", 32'(state_comp), 0);
    chk("rst_start", 32'(comp_start), 0);
    chk("rst_init_wr", 32'(init_wr), 0);
    chk("rst_addr", 32'(init_addr), 0);
    chk("rst_frames", 32'(frame_cnt), 0);
    chk("rst_err", 32'(timeout_err), 0);
  endtask

  task automatic init_phase();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (init_wr !== 1'b1 && n < 8);
    for (int a = 0; a < 2**DIN_W; a++) begin
      if (a > 0) begin
        @(negedge clk); #1;
      end
      chk("init_wr", 32'(init_wr), 1);
      chk("init_addr", 32'(init_addr), 32'(a));
      chk("init_data", 32'(init_map_data), 32'(a >> (DIN_W - DOUT_W)));
      chk("init_gate", 32'(pix_ready_gate), 0);
    end
    @(negedge clk); #1;
    chk("init_done_wr", 32'(init_wr), 0);
    chk("idle_gate_go", 32'(pix_ready_gate), 32'(go));
  endtask

  // One frame: nbeats beats, comp_done dly cycles into COMP (beyond TMO => timeout).
  task automatic run_frame(input int nbeats, input int dly, input bit drop_go, input bit clr_tmo);
    int   acc = 0;
    int   n = 0;
    int   ncomp;
    logic exp_gate;
    while (acc < nbeats) begin
      @(negedge clk);
      if (acc == 0) go = 1'b1;
      if (drop_go && acc > 0 && acc == nbeats / 2) go = 1'b0;
      pix_valid = ($urandom_range(0, 3) != 0);
      rdy_ds    = ($urandom_range(0, 3) != 0);
      pix_sop   = (acc == 0);
      pix_eop   = (acc == nbeats - 1);
      comp_done = ($urandom_range(0, 7) == 0);
      exp_gate  = (acc > 0) ? 1'b1 : go;
      #1;
      chk("stat_gate", 32'(pix_ready_gate), 32'(exp_gate));
      chk("stat_comp", 32'(state_comp), 0);
      chk("stat_start", 32'(comp_start), 0);
      chk("stat_frames", 32'(frame_cnt), 32'(exp_frames));
      chk("stat_err", 32'(timeout_err), 32'(exp_err));
      if (pix_valid && rdy_ds && exp_gate) acc++;
      n++;
      if (n > 300) begin
        chk("beat_bound", 32'(acc), 32'(nbeats));
        pix_valid = 1'b0;
        return;
      end
    end
    for (int k = 1; k <= DRAIN; k++) begin
      @(negedge clk);
      pix_valid = 1'($urandom_range(0, 1));
      pix_sop   = 1'b0;
      pix_eop   = 1'b0;
      comp_done = 1'b0;
      #1;
      chk("drain_gate", 32'(pix_ready_gate), 0);
      chk("drain_start", 32'(comp_start), 32'(k == DRAIN));
      chk("drain_comp", 32'(state_comp), 32'(k == DRAIN));
    end
    ncomp = (dly <= TMO) ? dly : TMO;
    for (int c = 1; c <= ncomp; c++) begin
      @(negedge clk);
      pix_valid = 1'($urandom_range(0, 1));
      comp_done = (c == dly);
      err_clr   = clr_tmo && (dly > TMO) && (c == TMO);
      #1;
      chk("comp_state", 32'(state_comp), 1);
      chk("comp_start", 32'(comp_start), 0);
      chk("comp_gate", 32'(pix_ready_gate), 0);
      chk("comp_err", 32'(timeout_err), 32'(exp_err));
      chk("comp_frames", 32'(frame_cnt), 32'(exp_frames));
    end
    @(negedge clk);
    comp_done = 1'b0;
    err_clr   = 1'b0;
    pix_valid = 1'b0;
    if (dly <= TMO) exp_frames++;
    else exp_err = 1'b1;
    #1;
    chk("idle_state", 32'(state_comp), 0);
    chk("idle_gate", 32'(pix_ready_gate), 32'(go));
    chk("idle_frames", 32'(frame_cnt), 32'(exp_frames));
    chk("idle_err", 32'(timeout_err), 32'(exp_err));
  endtask

  task automatic post_frame(input bit drop);
    if (drop) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        pix_valid = 1'b1;
        pix_sop   = 1'b1;
        pix_eop   = 1'b1;
        rdy_ds    = 1'b1;
        #1;
        chk("park_gate", 32'(pix_ready_gate), 0);
        chk("park_comp", 32'(state_comp), 0);
      end
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sop   = 1'b0;
      pix_eop   = 1'b0;
      go        = 1'b1;
      #1;
      chk("unpark_gate", 32'(pix_ready_gate), 1);
      chk("unpark_comp", 32'(state_comp), 0);
    end
    if (exp_err && $urandom_range(0, 1) == 1) begin
      @(negedge clk);
      err_clr = 1'b1;
      #1;
      chk("clr_before", 32'(timeout_err), 1);
      @(negedge clk);
      err_clr = 1'b0;
      exp_err = 1'b0;
      #1;
      chk("clr_after", 32'(timeout_err), 0);
    end
    @(negedge clk);
    comp_done = 1'b1;
    #1;
    @(negedge clk);
    comp_done = 1'b0;
    #1;
    chk("idle_done_ign", 32'(frame_cnt), 32'(exp_frames));
    chk("idle_done_comp", 32'(state_comp), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded limit 500000", $time);
    $fatal(1);
  end

  initial begin
    int nb;
    int dly;
    bit drop;
    bit clr;
    rst       = 1'b1;
    go        = 1'b1;
    err_clr   = 1'b0;
    pix_valid = 1'b0;
    pix_sop   = 1'b0;
    pix_eop   = 1'b0;
    comp_done = 1'b0;
    rdy_ds    = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    rst = 1'b0;
    init_phase();

    run_frame(4, 20, 1'b0, 1'b0);
    post_frame(1'b0);
    run_frame(1, 5, 1'b0, 1'b0);
    post_frame(1'b0);
    run_frame(3, 45, 1'b0, 1'b0);
    @(negedge clk);
    err_clr = 1'b1;
    #1;
    chk("tmo_err_set", 32'(timeout_err), 1);
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    #1;
    chk("tmo_err_clr", 32'(timeout_err), 0);
    run_frame(2, 40, 1'b0, 1'b1);
    post_frame(1'b0);
    run_frame(6, 10, 1'b1, 1'b0);
    post_frame(1'b1);

    repeat (30) begin
      nb   = $urandom_range(1, 8);
      dly  = $urandom_range(1, 40);
      drop = (nb > 1) && ($urandom_range(0, 5) == 0);
      clr  = 1'($urandom_range(0, 1));
      run_frame(nb, dly, drop, clr);
      post_frame(drop);
    end

    @(negedge clk);
    dut.frame_cnt <= 16'hFFFF;
    exp_frames = 16'hFFFF;
    run_frame(2, 3, 1'b0, 1'b0);
    chk("wrap_zero", 32'(frame_cnt), 0);
    post_frame(1'b0);

    run_frame(2, 50, 1'b0, 1'b0);
    @(negedge clk);
    go        = 1'b1;
    pix_valid = 1'b1;
    pix_sop   = 1'b1;
    pix_eop   = 1'b1;
    rdy_ds    = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sop   = 1'b0;
    pix_eop   = 1'b0;
    repeat (DRAIN + 2) @(negedge clk);
    #1;
    chk("pre_rst_comp", 32'(state_comp), 1);
    #2;
    rst = 1'b1;
    #1;
    exp_frames = 16'd0;
    exp_err    = 1'b0;
    chk_reset();
    @(negedge clk);
    rst = 1'b0;
    init_phase();
    run_frame(2, 4, 1'b0, 1'b0);
    post_frame(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
